// File: rtl/clk_ratio_mon.sv
// clk_ratio_mon: measures i_div_clk period in i_ref_clk cycles and flags lock/errors.
// Optional high-time (duty) check enabled by defining CLK_RATIO_MON_DUTY_EN.
module clk_ratio_mon #(
    parameter int RATIO_WD = 8,
    parameter int LOCK_CNT = 4
) (
    input  logic                i_ref_clk,
    input  logic                i_rst,
    input  logic                i_mon_en,
    input  logic                i_div_clk,
    input  logic [RATIO_WD-1:0] i_exp_ratio,
    output logic [RATIO_WD-1:0] o_meas_ratio,
    output logic                o_meas_valid,
    output logic                o_lock,
    output logic                o_err
);
    typedef enum logic [1:0] {IDLE, WAIT_EDGE, MEASURE} state_t;
    localparam logic [3:0] LOCK = 4'(LOCK_CNT);
    state_t              state;
    logic [2:0]          sync;
    logic [RATIO_WD-1:0] cnt;
    logic [RATIO_WD-1:0] exp_q;
    logic [3:0]          match;
    logic [3:0]          match_inc;
    logic                rise;
    logic                active;
    assign rise      = sync[1] & ~sync[2];
    assign active    = i_mon_en && (i_exp_ratio >= RATIO_WD'(2));
    assign match_inc = (match == LOCK) ? match : match + 4'd1;
`ifdef CLK_RATIO_MON_DUTY_EN
    logic [RATIO_WD-1:0] hcnt;
    logic [RATIO_WD-1:0] exp_high;
    logic                h_run;
    logic                fall;
    assign fall     = ~sync[1] & sync[2];
    assign exp_high = i_exp_ratio - (i_exp_ratio >> 1);
`endif
    always_ff @(posedge i_ref_clk or negedge i_rst) begin
        if (!i_rst) begin
            state        <= IDLE;
            sync         <= '0;
            cnt          <= '0;
            exp_q        <= '0;
            match        <= '0;
            o_meas_ratio <= '0;
            o_meas_valid <= 1'b0;
            o_lock       <= 1'b0;
            o_err        <= 1'b0;
`ifdef CLK_RATIO_MON_DUTY_EN
            hcnt         <= '0;
            h_run        <= 1'b0;
`endif
        end else begin
            sync         <= {sync[1:0], i_div_clk};
            exp_q        <= i_exp_ratio;
            o_meas_valid <= 1'b0;
            o_err        <= 1'b0;
            if (!active) begin
                state  <= IDLE;
                match  <= '0;
                o_lock <= 1'b0;
            end else begin
                case (state)
                    IDLE: state <= WAIT_EDGE;
                    WAIT_EDGE: begin
                        if (rise) begin
                            cnt   <= RATIO_WD'(1);
                            state <= MEASURE;
                        end
                    end
                    MEASURE: begin
                        if (rise) begin
                            cnt          <= RATIO_WD'(1);
                            o_meas_ratio <= cnt;
                            o_meas_valid <= 1'b1;
                            if (cnt == i_exp_ratio) begin
                                match  <= match_inc;
                                o_lock <= (match_inc == LOCK);
                            end else begin
                                match  <= '0;
                                o_lock <= 1'b0;
                                o_err  <= 1'b1;
                            end
                        end else if (&cnt) begin
                            // saturated without an edge: timeout, resync on next edge
                            o_err  <= 1'b1;
                            match  <= '0;
                            o_lock <= 1'b0;
                            state  <= WAIT_EDGE;
                        end else begin
                            cnt <= cnt + RATIO_WD'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
`ifdef CLK_RATIO_MON_DUTY_EN
            if (!active) begin
                h_run <= 1'b0;
            end else if (rise && state != IDLE) begin
                h_run <= 1'b1;
                hcnt  <= RATIO_WD'(1);
            end else if (h_run && fall) begin
                h_run <= 1'b0;
                if (hcnt != exp_high) begin
                    o_err  <= 1'b1;
                    match  <= '0;
                    o_lock <= 1'b0;
                end
            end else if (h_run && !(&hcnt)) begin
                hcnt <= hcnt + RATIO_WD'(1);
            end
`endif
            // a changed target invalidates any accumulated lock
            if (exp_q != i_exp_ratio) begin
                match  <= '0;
                o_lock <= 1'b0;
            end
        end
    end
endmodule
